// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO result registers.
//
// A multiply or divide is accepted in IDLE and runs for a fixed number of
// cycles. busy stays high for that whole time. HI/LO are written only on the
// edge where busy drops. Multiplies wait MUL_LAT cycles and then take the
// product of the latched operands. Divides use a restoring algorithm:
//   - one cycle to form the operand magnitudes,
//   - WIDTH cycles of shift/subtract, one quotient bit per cycle,
//   - one cycle to apply the signs and commit.
// mthi/mtlo writes land directly in HI/LO while the unit is idle.
//
// Handshake: mnd and mnd_we are single-cycle requests. Each is acted on only
// when the unit is idle (busy=0) and cancel is low in that same cycle. A
// request that arrives while busy=1 is dropped rather than queued, so the
// pipeline must hold mfhi/mflo/mnd until busy=0. When mnd and mnd_we arrive
// together, mnd wins and the write is dropped.

module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mnd,
  input  logic [1:0]       mndop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mnd_we,
  input  logic             HiLo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hi_lo_sel,
  input  logic             cancel,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int DIV_LAT = WIDTH + 2;
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  // Counter load values: the count reaches zero in the final busy cycle.
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic             op_signed_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  // Divider working registers: quotient/dividend shift register,
  // partial remainder and divisor magnitude.
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;

  // Control decode.
  logic is_idle;
  logic start;
  logic wr_direct;
  logic last_cycle;
  logic commit;
  logic div_abs_cycle;
  logic div_iter_cycle;

  assign is_idle        = (state_q == S_IDLE);
  assign start          = is_idle && mnd && !cancel;
  assign wr_direct      = is_idle && mnd_we && !mnd && !cancel;
  assign last_cycle     = !is_idle && (cnt_q == '0);
  assign commit         = last_cycle && !cancel;
  assign div_abs_cycle  = (state_q == S_DIV) && (cnt_q == DIV_LOAD);
  assign div_iter_cycle = (state_q == S_DIV) && (cnt_q != DIV_LOAD) && (cnt_q != '0);

  // Multiplier datapath: extend both operands to 2*WIDTH. Sign-extend for
  // mult, zero-extend for multu, so that a single unsigned multiply gives
  // the correct low 2*WIDTH bits in both cases.
  logic [2*WIDTH-1:0] ext_a, ext_b, product;

  always_comb begin
    ext_a   = op_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = op_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    product = ext_a * ext_b;
  end

  // Divider datapath: operand magnitudes, one restoring step, and the
  // final sign fix with the divide-by-zero override.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] div_lo, div_hi;

  always_comb begin
    a_neg     = op_signed_q & a_q[WIDTH-1];
    b_neg     = op_signed_q & b_q[WIDTH-1];
    a_abs     = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs     = b_neg ? (~b_q + 1'b1) : b_q;
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    // rem_q < divisor always holds, so a negative difference shows up as a
    // set top bit (borrow) and a positive one fits in WIDTH bits.
    rem_diff  = rem_shift - {1'b0, dvs_q};
    if (b_q == '0) begin
      div_lo = '1;
      div_hi = a_q;
    end else begin
      // Quotient is negative when the signs differ; the remainder follows
      // the dividend. The most-negative / -1 case falls out naturally: the
      // magnitude quotient 2^(WIDTH-1) is not negated and equals a.
      div_lo = (a_neg ^ b_neg) ? (~quo_q + 1'b1) : quo_q;
      div_hi = a_neg ? (~rem_q + 1'b1) : rem_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: start from IDLE; leave MUL/DIV on cancel or on the last cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = mndop[1] ? S_DIV : S_MUL;
      end
      S_MUL, S_DIV: begin
        if (cancel || (cnt_q == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Remaining-cycle down-counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= mndop[1] ? DIV_LOAD : MUL_LOAD;
    end else if (!is_idle) begin
      if (cancel || (cnt_q == '0)) cnt_q <= '0;
      else                         cnt_q <= cnt_q - CW'(1);
    end
  end

  // Operand latch at start; later changes on a/b do not affect the operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      op_signed_q <= 1'b0;
    end else if (start) begin
      a_q         <= a;
      b_q         <= b;
      op_signed_q <= mndop[0];
    end
  end

  // Restoring divider: load magnitudes, then shift in one quotient bit per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (div_abs_cycle) begin
      quo_q <= a_abs;
      rem_q <= '0;
      dvs_q <= b_abs;
    end else if (div_iter_cycle) begin
      quo_q <= {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
      rem_q <= rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    end
  end

  // HI/LO registers: result commit on the final busy edge, or a direct idle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (state_q == S_MUL) begin
        hi_q <= product[2*WIDTH-1:WIDTH];
        lo_q <= product[WIDTH-1:0];
      end else begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
    end else if (wr_direct) begin
      if (HiLo) hi_q <= wdata;
      else      lo_q <= wdata;
    end
  end

  assign rdata     = hi_lo_sel ? lo_q : hi_q;
  assign busy      = !is_idle;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter (WIDTH=32, MUL_LAT=5).
// Expected HI/LO come from a plain-arithmetic reference model.

module tb_mdu_iter;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = W + 2;

  logic         clk;
  logic         reset;
  logic         mnd;
  logic [1:0]   mndop;
  logic [W-1:0] a, b;
  logic         mnd_we;
  logic         HiLo;
  logic [W-1:0] wdata;
  logic         hi_lo_sel;
  logic         cancel;
  logic [W-1:0] rdata;
  logic         busy;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_hi, exp_lo;

  mdu_iter #(.WIDTH(W), .MUL_LAT(ML)) dut (
    .clk       (clk),
    .reset     (reset),
    .mnd       (mnd),
    .mndop     (mndop),
    .a         (a),
    .b         (b),
    .mnd_we    (mnd_we),
    .HiLo      (HiLo),
    .wdata     (wdata),
    .hi_lo_sel (hi_lo_sel),
    .cancel    (cancel),
    .rdata     (rdata),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: HI/LO from the arithmetic meaning of each operation.
  function automatic void model_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint unsigned ux, uy;
    longint sx, sy;
    logic [2*W-1:0] p;
    int qx, qy;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        ux = longint'(x); uy = longint'(y);
        p = ux * uy;
        hi = p[2*W-1:W]; lo = p[W-1:0];
      end
      2'b01: begin
        sx = longint'($signed(x)); sy = longint'($signed(y));
        p = sx * sy;
        hi = p[2*W-1:W]; lo = p[W-1:0];
      end
      2'b10: begin
        if (y == 0) begin lo = '1; hi = x; end
        else begin lo = x / y; hi = x % y; end
      end
      default: begin
        if (y == 0) begin lo = '1; hi = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo = x; hi = '0; end
        else begin
          qx = $signed(x); qy = $signed(y);
          lo = qx / qy; hi = qx % qy;
        end
      end
    endcase
  endfunction

  // Driver helper: read HI and LO through the rdata mux.
  task automatic read_regs(output logic [W-1:0] hi, output logic [W-1:0] lo);
    hi_lo_sel = 1'b0; #1; hi = rdata;
    hi_lo_sel = 1'b1; #1; lo = rdata;
  endtask

  // Driver: direct HI/LO write pulse (no check).
  task automatic drive_write(input logic to_hi, input logic [W-1:0] d);
    mnd_we = 1'b1; HiLo = to_hi; wdata = d;
    @(posedge clk); #1;
    mnd_we = 1'b0;
    if (to_hi) exp_hi = d; else exp_lo = d;
  endtask

  // Full operation: start, check hold-while-busy, latency and result.
  // Called just after an active edge.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit with_we, input string name);
    logic [W-1:0] mh, ml, rh, rl;
    int n, lat;
    model_op(op, x, y, mh, ml);
    mnd = 1'b1; mndop = op; a = x; b = y;
    if (with_we) begin mnd_we = 1'b1; HiLo = 1'b1; wdata = ~exp_hi; end
    @(posedge clk); #1;
    mnd = 1'b0; mnd_we = 1'b0; a = $urandom; b = $urandom;
    read_regs(rh, rl);
    n_cmp++;
    if ({rh, rl} !== {exp_hi, exp_lo}) begin
      n_bad++;
      $display("FAIL %s_hold: got hi=%h lo=%h want hi=%h lo=%h", name, rh, rl, exp_hi, exp_lo);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
    lat = op[1] ? DL : ML;
    n_cmp++;
    if (n !== lat) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, n, lat);
    end
    exp_hi = mh; exp_lo = ml;
    read_regs(rh, rl);
    n_cmp++;
    if ({rh, rl} !== {exp_hi, exp_lo}) begin
      n_bad++;
      $display("FAIL %s_result: op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h",
               name, op, x, y, rh, rl, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] rh, rl;
    reset = 1'b1; mnd = 1'b0; mndop = 2'b00; a = '0; b = '0; mnd_we = 1'b0;
    HiLo = 1'b0; wdata = '0; hi_lo_sel = 1'b0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    read_regs(rh, rl);
    n_cmp++;
    if (busy !== 1'b0 || rh !== '0 || rl !== '0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, rh, rl);
    end
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0, "mult_dir");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, "multu_dir");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    for (int i = 0; i < 8; i++)
      run_op({1'b0, 1'($urandom_range(0, 1))}, $urandom, $urandom, 1'b0, "mul_rand");
  endtask

  task automatic test_div();
    logic [W-1:0] y;
    run_op(2'b10, 32'd100, 32'd7, 1'b0, "divu_dir");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    run_op(2'b11, 32'd9, 32'd0, 1'b0, "div_zero");
    run_op(2'b10, 32'hDEAD_BEEF, 32'd0, 1'b0, "divu_zero");
    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 1'b0, "div_negdiv");
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 1'b0, "divu_by1");
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       y = '0;
        1:       y = $urandom_range(1, 20);
        2:       y = -$urandom_range(1, 20);
        default: y = $urandom;
      endcase
      run_op({1'b1, 1'($urandom_range(0, 1))}, $urandom, y, 1'b0, "div_rand");
    end
  endtask

  task automatic test_direct_write();
    logic [W-1:0] rh, rl;
    drive_write(1'b1, $urandom);
    drive_write(1'b0, $urandom);
    read_regs(rh, rl);
    n_cmp++;
    if ({rh, rl} !== {exp_hi, exp_lo}) begin
      n_bad++;
      $display("FAIL direct_write: got hi=%h lo=%h want hi=%h lo=%h", rh, rl, exp_hi, exp_lo);
    end
  endtask

  task automatic test_cancel();
    logic [W-1:0] rh, rl, mh, ml;
    int n;
    drive_write(1'b1, 32'h0000_AAAA);
    // Cancel in busy cycle 10.
    mnd = 1'b1; mndop = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    mnd = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    read_regs(rh, rl);
    n_cmp++;
    if (busy !== 1'b0 || rh !== exp_hi || rl !== exp_lo) begin
      n_bad++;
      $display("FAIL cancel_mid: busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", busy, rh, rl, exp_hi, exp_lo);
    end
    // mthi and a fresh mnd mid-divide must both be ignored.
    model_op(2'b10, 32'd5000, 32'd13, mh, ml);
    mnd = 1'b1; mndop = 2'b10; a = 32'd5000; b = 32'd13;
    @(posedge clk); #1;
    mnd = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == 3) begin
        mnd_we = 1'b1; HiLo = 1'b1; wdata = 32'h55;
        mnd = 1'b1; mndop = 2'b00; a = 32'd3; b = 32'd3;
      end else begin
        mnd_we = 1'b0; mnd = 1'b0;
      end
      @(posedge clk); #1;
    end
    mnd_we = 1'b0; mnd = 1'b0;
    n_cmp++;
    if (n !== DL) begin
      n_bad++;
      $display("FAIL ignore_busy_latency: got %0d want %0d", n, DL);
    end
    exp_hi = mh; exp_lo = ml;
    read_regs(rh, rl);
    n_cmp++;
    if ({rh, rl} !== {exp_hi, exp_lo}) begin
      n_bad++;
      $display("FAIL ignore_busy_result: got hi=%h lo=%h want hi=%h lo=%h", rh, rl, exp_hi, exp_lo);
    end
  endtask

  task automatic test_cancel_last();
    logic [W-1:0] rh, rl;
    int n;
    mnd = 1'b1; mndop = 2'b01; a = 32'd1234; b = 32'd77;
    @(posedge clk); #1;
    mnd = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      cancel = (n == ML);
      @(posedge clk); #1;
    end
    cancel = 1'b0;
    read_regs(rh, rl);
    n_cmp++;
    if (n !== ML || rh !== exp_hi || rl !== exp_lo) begin
      n_bad++;
      $display("FAIL cancel_last: cycles=%0d hi=%h lo=%h want cycles=%0d hi=%h lo=%h",
               n, rh, rl, ML, exp_hi, exp_lo);
    end
  endtask

  task automatic test_cancel_idle();
    logic [W-1:0] rh, rl;
    mnd = 1'b1; mndop = 2'b00; a = 32'd9; b = 32'd9; cancel = 1'b1;
    @(posedge clk); #1;
    mnd = 1'b0; cancel = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL cancel_idle_mnd: busy=%b want 0", busy);
    end
    mnd_we = 1'b1; HiLo = 1'b0; wdata = ~exp_lo; cancel = 1'b1;
    @(posedge clk); #1;
    mnd_we = 1'b0; cancel = 1'b0;
    read_regs(rh, rl);
    n_cmp++;
    if ({rh, rl} !== {exp_hi, exp_lo}) begin
      n_bad++;
      $display("FAIL cancel_idle_we: got hi=%h lo=%h want hi=%h lo=%h", rh, rl, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rh, rl;
    drive_write(1'b1, 32'h1234_5678);
    drive_write(1'b0, 32'h9ABC_DEF0);
    mnd = 1'b1; mndop = 2'b01; a = 32'd6; b = 32'd7;
    @(posedge clk); #1;
    mnd = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    read_regs(rh, rl);
    n_cmp++;
    if (busy !== 1'b0 || rh !== '0 || rl !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, rh, rl);
    end
    exp_hi = '0; exp_lo = '0;
    // First cycle after reset deasserts, with a simultaneous mthi that must drop.
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1, "after_reset_we");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_op(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
             1'($urandom_range(0, 1)), "b2b");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_direct_write();
    test_cancel();
    test_cancel_last();
    test_cancel_idle();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (even, >=8).
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply latency in cycles (>=1); divide latency is fixed at DIV_LAT = WIDTH+2.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 mnd  input  1  start request, a multiply/divide.
REQ-007 mndop  input  2  operation: 00 multu, 01 mult, 10 divu, 11 div.
REQ-008 a, b  input  WIDTH each  rs/rt operands; b is the divisor.
REQ-009 mnd_we  input  1  direct HI/LO write (mthi/mtlo).
REQ-010 HiLo  input  1  write target: 1 HI, 0 LO.
REQ-011 wdata  input  WIDTH  direct-write data.
REQ-012 hi_lo_sel  input  1  read select: 0 HI, 1 LO.
REQ-013 cancel  input  1  abort the in-flight operation (exception/eret flush).
REQ-014 rdata  output  WIDTH  selected HI or LO, combinational from registers.
REQ-015 busy  output  1  operation in flight; pipeline stalls mfhi/mflo/mnd while high.

Function
REQ-016 States SHALL be IDLE, MUL, DIV; a down-counter SHALL track remaining cycles.
REQ-017 In IDLE, mnd=1 sampled at edge T SHALL latch a, b and mndop, then enter MUL (mndop[1]=0) or DIV (mndop[1]=1).
REQ-018 busy SHALL be 1 for exactly MUL_LAT cycles (multiply) or DIV_LAT cycles (divide) after edge T; HI/LO SHALL update on the edge on which busy falls, and that same edge SHALL return the FSM to IDLE.
REQ-019 Multiply SHALL produce a 2*WIDTH product: HI=upper, LO=lower half; mult is signed, multu unsigned.
REQ-020 Divide SHALL be restoring, one quotient bit per cycle: 1 cycle operand absolute value, WIDTH iterations, 1 cycle sign fix; LO=quotient, HI=remainder.
REQ-021 Signed div SHALL truncate toward zero; the remainder SHALL take the dividend's sign.
REQ-022 Divide by zero (both kinds) SHALL give LO=all ones, HI=a, with full DIV_LAT latency.
REQ-023 Signed overflow (a=most negative, b=-1) SHALL give LO=a, HI=0.
REQ-024 mnd_we=1 in IDLE SHALL write wdata into HI (HiLo=1) or LO (HiLo=0) at the next edge.
REQ-025 While busy, mnd and mnd_we SHALL be ignored (no restart, no write).
REQ-026 In IDLE, mnd and mnd_we in the same cycle: the operation SHALL start and the write SHALL be dropped.
REQ-027 cancel=1 while busy SHALL return to IDLE at the next edge with HI/LO unchanged and busy=0.
REQ-028 cancel=1 in IDLE SHALL suppress any mnd or mnd_we sampled in that cycle.
REQ-029 cancel in the final busy cycle SHALL win: the result SHALL be discarded.
REQ-030 rdata SHALL always show the current HI/LO registers, including pre-operation values while busy.

Reset
REQ-031 reset SHALL set HI=0, LO=0, state IDLE, counter 0, busy=0, rdata=0.
REQ-032 reset SHALL have priority over every input, including mid-operation; no partial result SHALL reach HI/LO.
REQ-033 mnd in the first cycle after reset deasserts SHALL be accepted normally.

Verification (WIDTH=32, MUL_LAT=5)
REQ-034 mult a=0xFFFFFFFD, b=5 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; multu same operands -> HI=0x00000004, LO=0xFFFFFFF1.
REQ-035 divu 100/7 -> busy 34 cycles; LO=14, HI=2; div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-036 div 9/0 -> after 34 cycles LO=0xFFFFFFFF, HI=9.
REQ-037 Preload HI=0xAAAA via mnd_we; start divu, cancel at cycle 10 -> busy=0 next cycle, HI=0xAAAA; mthi 0x55 mid-div (no cancel) -> ignored.
REQ-038 reset at cycle 3 of mult -> HI=LO=0, busy=0 next cycle; mnd with mnd_we in IDLE -> operation runs, write dropped.
